cic_out_shaper: RTL and testbench
=================================

// Module: cic_out_shaper
// PURPOSE
//  Downstream stage of the 3-stage CIC interpolator (23-bit signed output, new sample every 4 sclk).
//  Decimates the CIC output to its true 12.5 MSPS rate with its own phase counter.
//  Removes the CIC gain with round-half-up plus saturation, and optionally converts to offset binary.
//  Buffers samples in a small show-ahead FIFO with valid/ready handshake toward the DAC/serialiser.
// PARAMETERS
//  IN_W         23  input width (CIC output), signed
//  OUT_W        12  output width, signed range before offset conversion
//  SHIFT         8  right-shift removing CIC gain (R*M)^N/R = 256; must be >=1
//  DIV_NUM       3  phase counter terminal value; one sample per DIV_NUM+1 clocks
//  SAMPLE_PHASE  0  ph_cnt value at which data_in is captured (0..DIV_NUM)
//  FIFO_DEPTH    4  output FIFO entries, power of 2, >=2
//  OFFSET_BIN    1  1: invert MSB of output (offset binary); 0: two's complement
// PORTS
//  sclk      in   1      50 MHz system clock
//  rst_n     in   1      reset, asynchronous, active-low
//  data_in   in   IN_W   signed CIC output (combinational from upstream)
//  data_v    in   1      stream enable, same signal driving the CIC; low = flush
//  dout      out  OUT_W  FIFO head sample (format per OFFSET_BIN)
//  dout_v    out  1      FIFO non-empty
//  dout_rdy  in   1      consumer accepts dout when dout_v && dout_rdy
//  ovf_drop  out  1      one-cycle pulse: sample dropped, FIFO full
//  sat_cnt   out  16     saturating count of clipped samples
// BEHAVIOUR
//  Reset: ph_cnt=0, pipeline valids=0, FIFO empty, dout_v=0, ovf_drop=0, sat_cnt=0, dout=idle code.
//  Idle code: 0 in two's complement, i.e. 1<<(OUT_W-1) when OFFSET_BIN=1; dout shows it whenever dout_v=0.
//  ph_cnt: counts 0..DIV_NUM then wraps to 0 while data_v=1; forced to 0 on any cycle data_v=0.
//  cap = data_v && (ph_cnt==SAMPLE_PHASE).
//  Edge E0 (cap=1): s1 <= data_in + 2^(SHIFT-1), computed at IN_W+1 bits (no wrap); v1<=1.
//  Edge E1: s2 <= sat(s1 >>> SHIFT) to [-2^(OUT_W-1), 2^(OUT_W-1)-1], then OFFSET_BIN MSB inversion; v2<=1.
//  Edge E1 also: if clipped, sat_cnt++ (holds at 16'hFFFF); sat_cnt cleared only by rst_n.
//  Edge E2: if v2, write s2 into FIFO; dout_v is high in the cycle after E2 (FIFO empty before).
//  Pipeline latency: capture edge to dout_v = 3 edges.
//  FIFO: show-ahead, dout = mem[rd_ptr] while non-empty; pop on dout_v && dout_rdy at edge.
//  Full + write without pop: new sample discarded, FIFO unchanged, ovf_drop=1 for that cycle only.
//  Full + write + pop on same edge: both happen, no drop, count stays FIFO_DEPTH.
//  Empty + write + dout_rdy=1: no pop that edge (dout_v was 0); sample appears next cycle.
//  Pointers log2(FIFO_DEPTH)+1 bits; full/empty from MSB compare; wrap seamless.
//  data_v=0: v1,v2 cleared, FIFO flushed (pointers 0), dout_v=0 next cycle; sat_cnt kept.
//  Resuming data_v=1: ph_cnt starts at 0 on the first enabled cycle; first cap when ph_cnt==SAMPLE_PHASE.
//  rst_n low mid-stream: all state returns to reset values immediately (async), no partial output.
// TESTING
//  T1 data_v=1, data_in=25600 const, dout_rdy=1 -> dout=0x864 (100+2048), one dout_v pulse per 4 clk.
//  T2 rounding, OFFSET_BIN=0: data_in 128->1, 127->0, -128->0, -129->-1, 384->2.
//  T3 data_in=600000 -> dout 0xFFF, sat_cnt+1; data_in=-600000 -> dout 0x000, sat_cnt+1.
//  T4 dout_rdy=0 for 40 clk -> exactly 4 samples held, ovf_drop pulses for each later cap;
//     dout_rdy=1 -> the 4 oldest samples in order.
//  T5 data_v low 1 clk mid-stream with FIFO holding 3 -> dout_v=0 next cycle, dout=idle code;
//     restart -> first output 3 edges after first cap.
//  T6 rst_n asserted while FIFO full and sat_cnt=5 -> dout_v=0, sat_cnt=0, ovf_drop=0 asynchronously.

Source files
------------

// File: rtl/cic_out_shaper.sv
// Output stage after the CIC interpolator: decimate to the true sample rate, remove CIC gain with
// round-half-up and saturation, optional offset-binary coding, then a show-ahead FIFO toward the DAC.
module cic_out_shaper #(
   parameter int IN_W         = 23,
   parameter int OUT_W        = 12,
   parameter int SHIFT        = 8,
   parameter int DIV_NUM      = 3,
   parameter int SAMPLE_PHASE = 0,
   parameter int FIFO_DEPTH   = 4,
   parameter int OFFSET_BIN   = 1
) (
   input  logic                   sclk,
   input  logic                   rst_n,
   input  logic signed [IN_W-1:0] data_in,
   input  logic                   data_v,
   output logic [OUT_W-1:0]       dout,
   output logic                   dout_v,
   input  logic                   dout_rdy,
   output logic                   ovf_drop,
   output logic [15:0]            sat_cnt
);

   localparam int PH_W = (DIV_NUM < 1) ? 1 : $clog2(DIV_NUM + 1);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam logic [PH_W-1:0]  PH_LAST = PH_W'(DIV_NUM);
   localparam logic [PH_W-1:0]  PH_CAP  = PH_W'(SAMPLE_PHASE);
   localparam logic [OUT_W-1:0] IDLE    = (OFFSET_BIN != 0) ? {1'b1, {(OUT_W-1){1'b0}}} : '0;

   // One extra bit of headroom so the rounding offset can never wrap.
   function automatic logic signed [IN_W:0] round_half_up(input logic signed [IN_W-1:0] x);
      logic signed [IN_W:0] half;
      half            = '0;
      half[SHIFT-1]   = 1'b1;
      return $signed({x[IN_W-1], x}) + half;
   endfunction

   // Returns {clip, code}; code already carries the output coding.
   function automatic logic [OUT_W:0] sat_shape(input logic signed [IN_W:0] s);
      logic signed [IN_W:0] q;
      logic signed [IN_W:0] hi;
      logic signed [IN_W:0] lo;
      logic [OUT_W-1:0]     code;
      logic                 clip;
      q  = s >>> SHIFT;
      hi = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
      lo = ~hi;
      if (q > hi) begin
         code = {1'b0, {(OUT_W-1){1'b1}}};
         clip = 1'b1;
      end else if (q < lo) begin
         code = {1'b1, {(OUT_W-1){1'b0}}};
         clip = 1'b1;
      end else begin
         code = q[OUT_W-1:0];
         clip = 1'b0;
      end
      if (OFFSET_BIN != 0) code[OUT_W-1] = ~code[OUT_W-1];
      return {clip, code};
   endfunction

   logic [PH_W-1:0]       ph_cnt;
   logic                  cap_p0;
   logic signed [IN_W:0]  sum_p1;
   logic                  vld_p1;
   logic [OUT_W:0]        shaped_p1;
   logic [OUT_W-1:0]      code_p2;
   logic                  vld_p2;

   logic [OUT_W-1:0]      mem [FIFO_DEPTH];
   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic                  empty;
   logic                  full;
   logic                  pop;
   logic                  push;

   assign cap_p0    = data_v && (ph_cnt == PH_CAP);
   assign shaped_p1 = sat_shape(sum_p1);

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout_v   = !empty;
   assign pop      = dout_v && dout_rdy;
   assign push     = data_v && vld_p2 && (!full || pop);
   assign ovf_drop = data_v && vld_p2 && full && !pop;
   assign dout     = empty ? IDLE : mem[rd_ptr[AW-1:0]];

   // Control state: phase counter, stage valids, FIFO pointers, clip counter.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         ph_cnt  <= '0;
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         sat_cnt <= '0;
      end else if (!data_v) begin
         ph_cnt  <= '0;
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
      end else begin
         ph_cnt <= (ph_cnt == PH_LAST) ? '0 : ph_cnt + 1'b1;
         vld_p1 <= cap_p0;
         vld_p2 <= vld_p1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (vld_p1 && shaped_p1[OUT_W] && (sat_cnt != 16'hFFFF)) sat_cnt <= sat_cnt + 16'd1;
      end
   end

   // p0 -> p1: rounding offset added at capture.
   always_ff @(posedge sclk) begin
      if (cap_p0) sum_p1 <= round_half_up(data_in);
   end

   // p1 -> p2: shift, saturate and code.
   always_ff @(posedge sclk) begin
      if (vld_p1) code_p2 <= shaped_p1[OUT_W-1:0];
   end

   // p2 -> FIFO storage.
   always_ff @(posedge sclk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= code_p2;
   end

endmodule

// File: tb/tb_cic_out_shaper.sv
// Directed and randomized bench for cic_out_shaper against a queue-based sample-flow model.
module tb_cic_out_shaper;

   logic               sclk = 1'b0;
   logic               rst_n;
   logic signed [22:0] data_in;
   logic               data_v;
   logic [11:0]        dout;
   logic               dout_v;
   logic               dout_rdy;
   logic               ovf_drop;
   logic [15:0]        sat_cnt;

   cic_out_shaper dut (
      .sclk     (sclk),
      .rst_n    (rst_n),
      .data_in  (data_in),
      .data_v   (data_v),
      .dout     (dout),
      .dout_v   (dout_v),
      .dout_rdy (dout_rdy),
      .ovf_drop (ovf_drop),
      .sat_cnt  (sat_cnt)
   );

   always #5 sclk = ~sclk;

   typedef struct {
      int         cap;
      logic [11:0] code;
      bit         clip;
   } pend_t;

   pend_t       pq[$];
   logic [11:0] fq[$];
   int          m_ph, m_n, m_sat;
   int          checks, errors;
   logic        obs_v, obs_ovf;
   logic [11:0] obs_d;

   // Reference transfer: divide by 256 rounding half up, clamp to 12-bit signed, add 2048 for offset binary.
   function automatic logic [11:0] shape(input int x, output bit clip);
      real r;
      int  v;
      r    = $floor((x + 128.0) / 256.0);
      v    = $rtoi(r);
      clip = 1'b0;
      if (v > 2047) begin
         v = 2047; clip = 1'b1;
      end else if (v < -2048) begin
         v = -2048; clip = 1'b1;
      end
      return 12'(v + 2048);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      pq.delete();
      fq.delete();
      m_ph  = 0;
      m_sat = 0;
   endtask

   // One clock: drive, check outputs at negedge, advance the model at the rising edge.
   task automatic step(input int din, input logic dv, input logic rdy);
      int    due_i;
      bit    pop;
      bit    c;
      pend_t e;
      data_in  = 23'(din);
      data_v   = dv;
      dout_rdy = rdy;
      @(negedge sclk);
      due_i = -1;
      foreach (pq[i]) if (pq[i].cap == m_n - 2) due_i = i;
      obs_v   = dout_v;
      obs_d   = dout;
      obs_ovf = ovf_drop;
      chk("dout_v", dout_v, fq.size() != 0);
      chk("dout", dout, (fq.size() != 0) ? fq[0] : 12'h800);
      chk("ovf_drop", ovf_drop, dv && (fq.size() == 4) && !rdy && (due_i >= 0));
      chk("sat_cnt", sat_cnt, m_sat);
      @(posedge sclk);
      if (!dv) begin
         pq.delete();
         fq.delete();
         m_ph = 0;
      end else begin
         pop = (fq.size() != 0) && rdy;
         foreach (pq[i]) if (pq[i].cap == m_n - 1 && pq[i].clip && m_sat < 65535) m_sat++;
         if (pop) void'(fq.pop_front());
         if (due_i >= 0 && fq.size() < 4) fq.push_back(pq[due_i].code);
         if (m_ph == 0) begin
            e.cap  = m_n;
            e.code = shape(din, c);
            e.clip = c;
            pq.push_back(e);
         end
         m_ph = (m_ph + 1) % 4;
         for (int i = pq.size() - 1; i >= 0; i--) if (pq[i].cap <= m_n - 2) pq.delete(i);
      end
      m_n++;
      #1;
   endtask

   initial begin
      int          cnt, k, first, ovfs, din;
      logic [11:0] last;
      logic [11:0] t2_got[5];
      int          t2_in[5];
      logic [11:0] t2_exp[5];
      int          held[4];
      bit          c;

      checks = 0; errors = 0; m_n = 0;
      model_reset();
      rst_n = 1'b0; data_in = '0; data_v = 1'b0; dout_rdy = 1'b0;
      #2;
      chk("rst_dout_v", dout_v, 0);
      chk("rst_dout", dout, 12'h800);
      chk("rst_ovf", ovf_drop, 0);
      chk("rst_sat", sat_cnt, 0);
      repeat (2) @(posedge sclk);
      #1 rst_n = 1'b1;
      step(0, 0, 1);

      // T1: constant 25600 -> 100 -> 0x864, one output per 4 clocks
      for (int i = 0; i < 12; i++) step(25600, 1, 1);
      cnt = 0; last = '0;
      for (int i = 0; i < 16; i++) begin
         step(25600, 1, 1);
         if (obs_v) begin cnt++; last = obs_d; end
      end
      chk("t1_pulses", cnt, 4);
      chk("t1_code", last, 12'h864);

      // T2: rounding boundaries
      t2_in  = '{128, 127, -128, -129, 384};
      t2_exp = '{12'h801, 12'h800, 12'h800, 12'h7FF, 12'h802};
      step(0, 0, 1);
      k = 0;
      for (int i = 0; i < 24; i++) begin
         step((i < 20) ? t2_in[i / 4] : 0, 1, 1);
         if (obs_v && k < 5) begin t2_got[k] = obs_d; k++; end
      end
      chk("t2_count", k, 5);
      for (int i = 0; i < 5; i++) chk("t2_round", t2_got[i], t2_exp[i]);

      // T3: saturation both ways
      step(0, 0, 1);
      k = 0;
      for (int i = 0; i < 12; i++) begin
         step((i < 4) ? 600000 : ((i < 8) ? -600000 : 0), 1, 1);
         if (obs_v && k < 2) begin t2_got[k] = obs_d; k++; end
      end
      chk("t3_hi", t2_got[0], 12'hFFF);
      chk("t3_lo", t2_got[1], 12'h000);
      chk("t3_sat", sat_cnt, 2);

      // T4: consumer stalled 40 clocks
      step(0, 0, 0);
      ovfs = 0;
      for (int i = 0; i < 40; i++) begin
         din = int'($urandom_range(0, 800000)) - 400000;
         if (i % 4 == 0 && i / 4 < 4) held[i / 4] = din;
         step(din, 1, 0);
         if (obs_ovf) ovfs++;
      end
      chk("t4_ovf_count", ovfs, 6);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 1);
         chk("t4_order", obs_d, shape(held[i], c));
      end

      // T5: flush with 3 held, then restart latency
      step(0, 0, 0);
      k = 0;
      while (fq.size() != 3 && k < 40) begin
         step(int'($urandom_range(0, 200000)) - 100000, 1, 0);
         k++;
      end
      chk("t5_fill", k < 40, 1);
      step(0, 0, 0);
      chk("t5_held_before", obs_v, 1);
      first = 0;
      for (int i = 0; i < 8; i++) begin
         step(25600, 1, 1);
         if (i == 0) begin
            chk("t5_flush_v", obs_v, 0);
            chk("t5_idle", obs_d, 12'h800);
         end
         if (obs_v && first == 0) first = i + 1;
      end
      chk("t5_latency", first, 4);

      // T6: async reset with FIFO full and sat_cnt at 5
      step(0, 0, 0);
      for (int i = 0; i < 24; i++) step((i < 12) ? 700000 : 1000, 1, 0);
      chk("t6_sat5", sat_cnt, 5);
      chk("t6_full_v", dout_v, 1);
      data_v = 1'b1; dout_rdy = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_dout_v", dout_v, 0);
      chk("t6_sat", sat_cnt, 0);
      chk("t6_ovf", ovf_drop, 0);
      chk("t6_dout", dout, 12'h800);
      model_reset();
      @(posedge sclk);
      #1 rst_n = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         step(int'($urandom_range(0, 1400000)) - 700000,
              $urandom_range(0, 19) != 0, $urandom_range(0, 2) != 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
